// File: rtl/pwm_multichannel_peripheral_pkg.sv
// Shared constants and types for the multichannel PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_NUM_CH  = 16;
  localparam int unsigned PWM_CNT_W   = 8;
  localparam int unsigned PWM_PRESC_W = 8;

  typedef enum logic {
    PWM_MODE_STATIC = 1'b0,
    PWM_MODE_PWM    = 1'b1
  } pwm_mode_e;

  // Channel-index width; a single channel still needs a 1-bit select.
  function automatic int unsigned ch_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multichannel_peripheral_if.sv
// Register-side control bus and PWM outputs of the multichannel PWM peripheral.
interface pwm_multichannel_peripheral_if
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH  = PWM_NUM_CH,
  parameter int unsigned CNT_W   = PWM_CNT_W,
  parameter int unsigned PRESC_W = PWM_PRESC_W
);
  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic               run;
  logic [PRESC_W-1:0] prescale;
  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic               duty_wr;
  logic [CH_W-1:0]    duty_ch;
  logic [CNT_W-1:0]   duty_data;
  logic               period_start;
  logic [NUM_CH-1:0]  out;

  modport master (
    output run, prescale, en_out, en_pwm, duty_wr, duty_ch, duty_data,
    input  period_start, out
  );

  modport slave (
    input  run, prescale, en_out, en_pwm, duty_wr, duty_ch, duty_data,
    output period_start, out
  );

endinterface

// File: rtl/pwm_multichannel_peripheral_timebase.sv
// Prescaled period counter: emits the counter value, the wrap condition and a registered period-start pulse.
module pwm_timebase #(
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_wrap,
  output logic               o_period_start
);

  logic [PRESC_W-1:0] r_psc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_period_start;
  logic               w_tick;

  // >= so that lowering prescale below the running count wraps immediately.
  assign w_tick = i_run && (r_psc >= i_prescale);
  assign o_wrap = w_tick && (r_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc          <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= o_wrap;
      if (!i_run) begin
        r_psc <= '0;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_psc <= '0;
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_psc <= r_psc + PRESC_W'(1);
      end
    end
  end

  assign o_cnt          = r_cnt;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_multichannel_peripheral.sv
// N-channel PWM with per-channel double-buffered duty, shared prescaled timebase and registered outputs.
module pwm_multichannel_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH  = PWM_NUM_CH,
  parameter int unsigned CNT_W   = PWM_CNT_W,
  parameter int unsigned PRESC_W = PWM_PRESC_W
) (
  input logic                         clk,
  input logic                         rst,
  pwm_multichannel_peripheral_if.slave pwm_if
);

  logic [CNT_W-1:0]  r_pending [NUM_CH];
  logic [CNT_W-1:0]  r_active  [NUM_CH];
  logic [NUM_CH-1:0] r_out;
  logic [NUM_CH-1:0] w_pwm_bit;
  logic [NUM_CH-1:0] w_out_nxt;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_wrap;
  logic              w_period_start;

  pwm_timebase #(
    .PRESC_W (PRESC_W),
    .CNT_W   (CNT_W)
  ) u_timebase (
    .clk            (clk),
    .rst            (rst),
    .i_run          (pwm_if.run),
    .i_prescale     (pwm_if.prescale),
    .o_cnt          (w_cnt),
    .o_wrap         (w_wrap),
    .o_period_start (w_period_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) r_pending[i] <= '0;
    end else if (pwm_if.duty_wr && (32'(pwm_if.duty_ch) < NUM_CH)) begin
      r_pending[pwm_if.duty_ch] <= pwm_if.duty_data;
    end
  end

  // Active copies see pending as it was before this edge; a same-cycle write waits one period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) r_active[i] <= '0;
    end else if (w_wrap) begin
      r_active <= r_pending;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_pwm_bit[g] = (r_active[g] == '1) ? 1'b1 : (w_cnt < r_active[g]);
  end

  always_comb begin
    w_out_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pwm_if.en_out[i]) begin
        w_out_nxt[i] = (pwm_mode_e'(pwm_if.en_pwm[i]) == PWM_MODE_PWM) ? w_pwm_bit[i] : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= '0;
    else     r_out <= w_out_nxt;
  end

  assign pwm_if.out          = r_out;
  assign pwm_if.period_start = w_period_start;

endmodule
